// File: rtl/audio_alert_scheduler.sv
// Prioritised audio alert scheduler: latches event requests and plays a
// per-source beep pattern (tone divider + beep count) with gaps and a holdoff.
module audio_alert_scheduler #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned BEEP_MS  = 100,
    parameter int unsigned GAP_MS   = 50,
    parameter logic [16:0] DIV0     = 17'd25000,
    parameter logic [16:0] DIV1     = 17'd40000,
    parameter logic [16:0] DIV2     = 17'd50000,
    parameter logic [16:0] DIV3     = 17'd80000,
    parameter int unsigned NB0      = 3,
    parameter int unsigned NB1      = 2,
    parameter int unsigned NB2      = 1,
    parameter int unsigned NB3      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  req,
    output logic        tone_on,
    output logic [16:0] tone_div,
    output logic        busy,
    output logic [1:0]  active_src,
    output logic [3:0]  pending,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MS_MAX = (BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS;
    localparam int unsigned MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

    typedef enum logic [1:0] {IDLE, BEEP, GAP, HOLDOFF} state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic [2:0]        beep_left;

    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [3:0]        clear_mask;
    logic              drop_hit;
    logic              tick_last;
    logic              ms_last;
    logic              period_done;
    logic [16:0]       sel_div;
    logic [2:0]        sel_nb;

    // Grant selection, coalescing detection and phase-timer end detection
    always_comb begin
        grant_valid = enable && (state == IDLE) && (|pending);
        grant_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) grant_idx = 2'(i);
        end
        clear_mask  = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
        drop_hit    = |(req & pending & ~clear_mask);
        tick_last   = (tick_cnt == TICK_W'(TICK_DIV - 1));
        ms_last     = (state == BEEP) ? (ms_cnt == MS_W'(BEEP_MS - 1))
                                      : (ms_cnt == MS_W'(GAP_MS - 1));
        period_done = tick_last && ms_last;
        unique case (grant_idx)
            2'd0: begin sel_div = DIV0; sel_nb = 3'(NB0); end
            2'd1: begin sel_div = DIV1; sel_nb = 3'(NB1); end
            2'd2: begin sel_div = DIV2; sel_nb = 3'(NB2); end
            2'd3: begin sel_div = DIV3; sel_nb = 3'(NB3); end
        endcase
    end

    // Request latch: a new request in the grant cycle wins over the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= 4'b0000;
            drop_cnt <= 8'd0;
        end else begin
            pending <= (pending & ~clear_mask) | req;
            if (drop_hit && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Sequencer; the timer restarts on every state entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tone_on    <= 1'b0;
            busy       <= 1'b0;
            tone_div   <= 17'd0;
            active_src <= 2'd0;
            beep_left  <= 3'd0;
            tick_cnt   <= '0;
            ms_cnt     <= '0;
        end else if ((state != IDLE) && !enable) begin
            state    <= IDLE;
            tone_on  <= 1'b0;
            busy     <= 1'b0;
            tick_cnt <= '0;
            ms_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state      <= BEEP;
                        tone_on    <= 1'b1;
                        busy       <= 1'b1;
                        active_src <= grant_idx;
                        tone_div   <= sel_div;
                        beep_left  <= sel_nb;
                        tick_cnt   <= '0;
                        ms_cnt     <= '0;
                    end
                end
                BEEP, GAP, HOLDOFF: begin
                    if (period_done) begin
                        tick_cnt <= '0;
                        ms_cnt   <= '0;
                        if (state == BEEP) begin
                            beep_left <= beep_left - 3'd1;
                            tone_on   <= 1'b0;
                            state     <= (beep_left == 3'd1) ? HOLDOFF : GAP;
                        end else if (state == GAP) begin
                            tone_on <= 1'b1;
                            state   <= BEEP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (tick_last) begin
                        tick_cnt <= '0;
                        ms_cnt   <= ms_cnt + MS_W'(1);
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
